// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack clock-domain-crossing handshake blocks.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL
    } hs_state_t;

    localparam int unsigned CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_nff.sv
// N-stage level synchronizer for a single asynchronous bit; all stages reset to 0.
module sync_nff
    import cdc_pkg::*;
#(
    parameter int unsigned STAGES = CDC_MIN_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q_sync
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_async};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_sync = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Transmit end of the four-phase req/ack CDC handshake: captures a word, holds it
// on data_async, raises req_async and completes the return-to-zero phase.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic              clk_src,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              req_async,
    output logic [DATA_W-1:0] data_async,
    input  logic              ack_async,
    output logic              tx_done,
    output logic              err_timeout
);

    localparam int unsigned     CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    hs_state_t         state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              aborted_q, aborted_d;
    logic              ack_sync;

    sync_nff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk     (clk_src),
        .rst     (rst),
        .d_async (ack_async),
        .q_sync  (ack_sync)
    );

    always_ff @(posedge clk_src) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A genuine ack wins over a timeout expiring on the same edge.
                if (ack_sync) begin
                    req_d   = 1'b0;
                    state_d = REL;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    req_d     = 1'b0;
                    err_d     = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = REL;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REL: begin
                if (!ack_sync) begin
                    done_d    = !aborted_q;
                    aborted_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A stale ack still high (e.g. after a reset mid-transfer) blocks new requests.
    always_comb begin
        in_ready = (state_q == IDLE) && !ack_sync;
    end

    assign req_async   = req_q;
    assign data_async  = data_q;
    assign tx_done     = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Randomized and directed bench for cdc_handshake_tx against a transfer-level reference model.
module tb_cdc_handshake_tx;

    localparam int PH_IDLE = 0;  // free to accept
    localparam int PH_WAIT = 1;  // request raised, waiting for ack
    localparam int PH_DROP = 2;  // request withdrawn, waiting for ack to fall

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_valid;
    logic [7:0] in_data [2];
    logic [1:0] ack;
    logic [1:0] in_ready, req, done, err;
    logic [7:0] data [2];

    always #5 clk = ~clk;

    cdc_handshake_tx #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(0)) u_dut0 (
        .clk_src(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .req_async(req[0]), .data_async(data[0]),
        .ack_async(ack[0]), .tx_done(done[0]), .err_timeout(err[0])
    );

    cdc_handshake_tx #(.DATA_W(8), .SYNC_STAGES(3), .TIMEOUT(8)) u_dut1 (
        .clk_src(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .req_async(req[1]), .data_async(data[1]),
        .ack_async(ack[1]), .tx_done(done[1]), .err_timeout(err[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: ack_sync is simply the ack seen (stages-1) edges ago, zeroed by any
    // reset inside that window; timeouts are measured as edges elapsed since the accept.
    int       stages [2] = '{2, 3};
    int       tmo    [2] = '{0, 8};
    int       ncyc     = 0;
    int       last_rst = -1;
    bit       ack_at [2][2048];
    int       m_phase [2];
    bit       m_req [2], m_done [2], m_err [2], m_abort [2];
    logic [7:0] m_data [2];
    int       m_acc_edge [2];
    bit       acc_dut [2];

    bit fe_auto [2];
    int fe_rise [2], fe_fall [2], fe_hi [2], fe_lo [2];

    function automatic bit sync_after(input int i, input int n);
        int e;
        e = n - stages[i] + 1;
        if (e < 1 || e <= last_rst) return 1'b0;
        return ack_at[i][e];
    endfunction

    task automatic model_edge(input int i);
        bit s;
        s = sync_after(i, ncyc - 1);
        m_done[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (rst) begin
            m_phase[i] = PH_IDLE;
            m_req[i]   = 1'b0;
            m_data[i]  = 8'h00;
            m_abort[i] = 1'b0;
        end else if (m_phase[i] == PH_IDLE) begin
            if (in_valid[i] && !s) begin
                m_data[i]     = in_data[i];
                m_req[i]      = 1'b1;
                m_acc_edge[i] = ncyc;
                m_phase[i]    = PH_WAIT;
            end
        end else if (m_phase[i] == PH_WAIT) begin
            if (s) begin
                m_req[i]   = 1'b0;
                m_phase[i] = PH_DROP;
            end else if (tmo[i] != 0 && (ncyc - m_acc_edge[i]) == tmo[i]) begin
                m_req[i]   = 1'b0;
                m_err[i]   = 1'b1;
                m_abort[i] = 1'b1;
                m_phase[i] = PH_DROP;
            end
        end else begin
            if (!s) begin
                m_done[i]  = !m_abort[i];
                m_abort[i] = 1'b0;
                m_phase[i] = PH_IDLE;
            end
        end
    endtask

    // Far end: raises ack fe_rise cycles after seeing req, drops it fe_fall cycles after req falls.
    task automatic far_end(input int i);
        if (!fe_auto[i]) return;
        if (req[i]) begin
            fe_lo[i] = 0;
            if (fe_hi[i] >= fe_rise[i]) ack[i] = 1'b1;
            fe_hi[i]++;
        end else begin
            fe_hi[i] = 0;
            if (ack[i]) begin
                if (fe_lo[i] >= fe_fall[i]) ack[i] = 1'b0;
                fe_lo[i]++;
            end else begin
                fe_lo[i] = 0;
            end
        end
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++) acc_dut[i] = in_valid[i] && in_ready[i];
        @(posedge clk);
        ncyc++;
        if (rst) last_rst = ncyc;
        for (int i = 0; i < 2; i++) begin
            ack_at[i][ncyc] = ack[i];
            model_edge(i);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            far_end(i);
            check($sformatf("req%0d@%0d", i, ncyc), req[i], m_req[i]);
            check($sformatf("data%0d@%0d", i, ncyc), data[i], m_data[i]);
            check($sformatf("done%0d@%0d", i, ncyc), done[i], m_done[i]);
            check($sformatf("err%0d@%0d", i, ncyc), err[i], m_err[i]);
            check($sformatf("ready%0d@%0d", i, ncyc), in_ready[i],
                  (m_phase[i] == PH_IDLE) && !sync_after(i, ncyc));
            check($sformatf("excl%0d@%0d", i, ncyc), done[i] && err[i], 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   gap_a, gap_b, n_acc, n_done, rise_cyc, fall_cyc, err_j;
        bit   got_done, prev_req, prev_ack;
        logic [7:0] held, w;

        rst = 1'b1;
        ack = 2'b00;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b1;
            in_data[i]  = 8'hA5;
            fe_auto[i]  = 1'b0;
            fe_hi[i]    = 0;
            fe_lo[i]    = 0;
        end

        // Reset with a pending upstream word
        repeat (3) step();
        check("rst_req", req[0], 1'b0);
        check("rst_data", data[0], 8'h00);
        check("rst_ready", in_ready[0], 1'b1);
        check("rst_done", done[0], 1'b0);
        check("rst_err", err[0], 1'b0);
        check("rst_req1", req[1], 1'b0);
        in_valid = 2'b00;
        rst = 1'b0;
        step();

        // Loopback single transfer
        fe_auto[0] = 1'b1; fe_rise[0] = 0; fe_fall[0] = 0;
        in_data[0] = 8'h3C; in_valid[0] = 1'b1;
        step();
        check("lb_acc", acc_dut[0], 1'b1);
        in_valid[0] = 1'b0;
        for (int j = 0; j <= 7; j++) begin
            if (j > 0) step();
            check($sformatf("lb_req_k%0d", j), req[0], j <= 2);
            check($sformatf("lb_done_k%0d", j), done[0], j == 6);
            check($sformatf("lb_data_k%0d", j), data[0], 8'h3C);
        end

        // Back-to-back words
        in_data[0] = 8'h01; in_valid[0] = 1'b1;
        n_acc = 0; n_done = 0; gap_a = 0; gap_b = 0; prev_req = 1'b0; held = 8'h00;
        for (int t = 0; t < 20; t++) begin
            step();
            if (acc_dut[0]) begin
                n_acc++;
                if (n_acc == 1) begin gap_a = ncyc; in_data[0] = 8'h02; end
                if (n_acc == 2) begin gap_b = ncyc; in_valid[0] = 1'b0; end
            end
            if (done[0]) n_done++;
            if (req[0] && !prev_req) held = data[0];
            if (req[0]) check("b2b_stable", data[0], held);
            prev_req = req[0];
        end
        check("b2b_accepts", n_acc, 2);
        check("b2b_gap", gap_b - gap_a, 7);
        check("b2b_dones", n_done, 2);

        // Slow far end
        fe_rise[0] = 10; fe_fall[0] = 5;
        w = 8'($urandom);
        in_data[0] = w; in_valid[0] = 1'b1;
        step();
        check("slow_acc", acc_dut[0], 1'b1);
        in_valid[0] = 1'b0;
        got_done = 1'b0; rise_cyc = -100; fall_cyc = 0; prev_ack = ack[0]; prev_req = req[0];
        for (int t = 0; t < 60 && !got_done; t++) begin
            step();
            if (ack[0] && !prev_ack) rise_cyc = ncyc;
            if (!req[0] && prev_req) fall_cyc = ncyc;
            if (done[0]) got_done = 1'b1;
            else check("slow_ready", in_ready[0], 1'b0);
            prev_ack = ack[0];
            prev_req = req[0];
        end
        check("slow_done_seen", got_done, 1'b1);
        check("slow_req_drop", fall_cyc - rise_cyc, 3);
        check("slow_data", data[0], w);

        // Timeout with ack held low (DUT1)
        ack[1] = 1'b0;
        in_data[1] = 8'($urandom); in_valid[1] = 1'b1;
        step();
        check("to_acc", acc_dut[1], 1'b1);
        in_valid[1] = 1'b0;
        err_j = -1;
        for (int j = 1; j <= 20 && err_j < 0; j++) begin
            step();
            if (err[1]) err_j = j;
        end
        check("to_cycle", err_j, 8);
        check("to_req", req[1], 1'b0);
        step();
        check("to_no_done", done[1], 1'b0);
        check("to_idle_ready", in_ready[1], 1'b1);

        // Reset mid-REQ with ack held high
        repeat (8) step();
        fe_auto[0] = 1'b0; ack[0] = 1'b0;
        in_data[0] = 8'h5A; in_valid[0] = 1'b1;
        step();
        check("mr_acc", acc_dut[0], 1'b1);
        in_valid[0] = 1'b0;
        ack[0] = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("mr_req", req[0], 1'b0);
        rst = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            step();
            if (t >= 2) check($sformatf("mr_stale_ready_%0d", t), in_ready[0], 1'b0);
            check($sformatf("mr_no_req_%0d", t), req[0], 1'b0);
        end
        ack[0] = 1'b0;
        step();
        check("mr_ready_f1", in_ready[0], 1'b0);
        step();
        check("mr_ready_f2", in_ready[0], 1'b1);

        // Randomized traffic on both instances
        for (int i = 0; i < 2; i++) begin
            fe_auto[i] = 1'b1; fe_hi[i] = 0; fe_lo[i] = 0;
            fe_rise[i] = $urandom_range(0, 12); fe_fall[i] = $urandom_range(0, 6);
        end
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < 2; i++) begin
                in_valid[i] = 1'($urandom_range(0, 1));
                in_data[i]  = 8'($urandom);
            end
            step();
            for (int i = 0; i < 2; i++) begin
                if (acc_dut[i]) begin
                    fe_rise[i] = $urandom_range(0, 12);
                    fe_fall[i] = $urandom_range(0, 6);
                end
            end
        end
        rst = 1'b0;
        in_valid = 2'b00;
        repeat (40) step();
        check("final_idle0", in_ready[0], 1'b1);
        check("final_idle1", in_ready[1], 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-domain (transmit) end of the team's four-phase req/ack clock-domain-crossing handshake. Accepts a data word with a valid/ready handshake in the `clk_src` domain and holds it stable on `data_async`. Raises `req_async` and waits for the far end's `ack_async`, which passes through an internal N-flop synchronizer, then completes the return-to-zero phase. It pairs with a destination-side receiver that synchronizes `req_async` and returns `ack_async`.

## Interface
- `DATA_W`, default 8: width of the transferred word.
- `SYNC_STAGES`, default 2: flops in the `ack_async` synchronizer; legal values are 2 or greater.
- `TIMEOUT`, default 0: number of cycles to wait in REQ for ack before aborting; 0 disables the timeout.

- `clk_src` in 1: single clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream word is valid.
- `in_ready` out 1: block can accept a word this cycle.
- `in_data` in `DATA_W`: upstream word.
- `req_async` out 1: request to the far domain. Driven directly from a flop.
- `data_async` out `DATA_W`: held word. Driven directly from a flop.
- `ack_async` in 1: acknowledge from the far domain. Asynchronous to `clk_src`.
- `tx_done` out 1: one-cycle pulse when a transfer completes successfully.
- `err_timeout` out 1: one-cycle pulse when a transfer is aborted by the timeout.

## Operation
- States: IDLE, REQ, REL. `ack_sync` is the final stage of the synchronizer.
- IDLE:
  - `in_ready = !ack_sync`. This is combinational from the state and `ack_sync`.
  - Accept occurs when `in_valid && in_ready`. On that edge: `data_async <= in_data`, `req_async <= 1`, timeout counter cleared, state goes to REQ.
- REQ:
  - If `ack_sync == 1`: `req_async <= 0`, state goes to REL.
  - Else, if `TIMEOUT != 0` and the counter equals `TIMEOUT-1`: `req_async <= 0`, `err_timeout <= 1` for one cycle, the aborted flag is set, state goes to REL.
  - Else the counter increments. The counter is `$clog2(TIMEOUT+1)` bits wide and saturates.
- REL:
  - When `ack_sync == 0`, state goes to IDLE.
  - `tx_done <= 1` for one cycle unless the aborted flag is set. The aborted flag is cleared on this edge.
- `data_async` changes only on an accept edge. It is stable from the rise of `req_async` until the next accept.
- `in_ready` is 0 in REQ and REL. `in_valid` in those states is ignored, with no data capture.
- Reset values:
  - state IDLE, `req_async` 0, `data_async` 0, `tx_done` 0, `err_timeout` 0, counter 0, aborted flag 0.
  - All synchronizer flops are 0.
- Reset mid-transfer: `req_async` drops to 0 on the reset edge. After reset, `in_ready` stays 0 while a stale `ack_sync` is 1, so no new request can be issued before the far end returns to zero.

## Timing
- Accept at edge k puts `req_async = 1` and the new `data_async` after edge k, on the same edge.
- Loopback case (`ack_async` tied to `req_async`), `SYNC_STAGES = 2`:
  - `ack_sync` is 1 after edge k+2.
  - `req_async` is 0 after edge k+3.
  - `ack_sync` is 0 after edge k+5.
  - IDLE with `tx_done = 1` after edge k+6.
  - Earliest next accept is at edge k+7, giving a 7-cycle period.
- General case: each synchronizer stage adds 2 cycles per transfer.
- `ack_async` pulses that are too short to be captured are not a legal far-end behavior. The far end holds ack until it sees req low.
- `tx_done` and `err_timeout` are never 1 in the same cycle.

## Structure
- A shared package `cdc_pkg` holds:
  - the state enum `hs_state_t` (IDLE, REQ, REL);
  - the constant `CDC_MIN_SYNC_STAGES = 2`.
- Sub-module `sync_nff` is a parameterized N-stage level synchronizer with ports clock, rst, d_async, q_sync. It is instantiated once for `ack_async`, and the matching receiver reuses it.
- The top level contains the FSM, data register, timeout counter and aborted flag.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `in_valid = 1` and `in_data = 8'hA5`.
  - Required: `req_async = 0`, `data_async = 0`, `in_ready = 1`, no pulses.
- **Loopback single transfer:** tie `ack_async = req_async` and send `8'h3C` with accept at edge k.
  - Required: `req_async` high after edges k to k+2; `data_async = 8'h3C` throughout; `tx_done` pulses after edge k+6 only.
- **Back-to-back:** hold `in_valid` with `8'h01`, then `8'h02`.
  - Required: accepts 7 cycles apart; `data_async` never changes while `req_async = 1`; exactly 2 `tx_done` pulses.
- **Slow far end:** ack rises 10 cycles after req, and falls 5 cycles after req drops.
  - Required: `req_async` drops exactly `SYNC_STAGES + 1` cycles after ack rises; `in_ready = 0` until `tx_done`.
- **Timeout:** `TIMEOUT = 8`, `ack_async` held 0.
  - Required: `err_timeout` pulses on the 8th cycle in REQ; `req_async` goes to 0; return to IDLE follows with no `tx_done`.
- **Reset mid-REQ with ack high:** assert `rst` for 1 cycle, keep `ack_async = 1` for 6 more cycles.
  - Required: `req_async = 0` immediately; `in_ready = 0` until 2 cycles after ack falls; no accept in between.
